ay8913_bus_writer: RTL
======================

// Module: ay8913_bus_writer
// PURPOSE
//  Host-side driver of the AY-3-891x register bus (BDIR/BC1 + 8-bit DA). Accepts (register, value) write
//  requests on a valid/ready handshake and emits the Latch-Address -> Inactive -> Write -> Inactive sequence,
//  holding each phase for programmable cycle counts. Sits in test harnesses/SoC glue in front of
//  tt_um_rejunity_ay8913 (bus_data->ui_in, bdir->uio_in[0], bc1->uio_in[1]). Optionally skips redundant latches.
// PARAMETERS
//  CHIP_MASK     4'b0000  upper nibble driven on DA7..DA4 during latch phase (chip select)
//  LATCH_CYCLES  2        cycles BDIR=1,BC1=1 held (>=1)
//  WRITE_CYCLES  2        cycles BDIR=1,BC1=0 held (>=1)
//  GAP_CYCLES    1        inactive cycles (BDIR=0,BC1=0) after each phase (>=0; 0 removes gap states)
//  SKIP_RELATCH  1        1: omit latch phase when target register equals last latched register
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  in_valid     in   1  write request valid
//  in_ready     out  1  block can accept request (high only in IDLE)
//  in_reg       in   4  target register R0..R15
//  in_data      in   8  value to write
//  cache_flush  in   1  invalidate latched-register cache (one-cycle pulse)
//  bus_data     out  8  DA7..DA0 to PSG
//  bdir         out  1  BDIR
//  bc1          out  1  BC1
//  wr_done      out  1  one-cycle pulse: a write sequence has completed
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, bus_data=0, bdir=0, bc1=0, wr_done=0, cache invalid; in_ready=1 once released.
//  - All bus outputs are registered; no combinational path from inputs to bus_data/bdir/bc1.
//  - States: IDLE, LATCH, GAP_A, WRITE, GAP_B. Phase counter sized to max(LATCH,WRITE,GAP)_CYCLES.
//  - IDLE: bdir=bc1=0, bus_data holds last value. Accept on in_valid&&in_ready at edge N: capture in_reg/in_data.
//    If SKIP_RELATCH && cache valid && in_reg==cached_reg -> WRITE, else -> LATCH. First phase visible at N+1.
//  - LATCH: bus_data={CHIP_MASK,reg}, bdir=1, bc1=1 for LATCH_CYCLES; cached_reg<=reg, cache valid on entry.
//  - GAP_A: bdir=bc1=0, bus_data unchanged, GAP_CYCLES; skipped if GAP_CYCLES==0.
//  - WRITE: bus_data=data, bdir=1, bc1=0 for WRITE_CYCLES.
//  - GAP_B: bdir=bc1=0, bus_data unchanged, GAP_CYCLES (skipped if 0), then IDLE.
//  - wr_done=1 for exactly the first IDLE cycle after a sequence; new request may be accepted in that cycle.
//  - Latency accept->wr_done: (latch?LATCH_CYCLES+GAP_CYCLES:0)+WRITE_CYCLES+GAP_CYCLES+1 cycles.
//  - in_valid outside IDLE is ignored (in_ready=0); requester must hold request per valid/ready rules.
//  - cache_flush: clears cache valid next cycle in any state; does not abort a running sequence.
//    Flush coincident with a LATCH entry: flush wins (cache invalid afterwards).
//    Flush coincident with acceptance: the skip decision uses pre-flush cache value.
//  - Reset mid-sequence: bus returns to inactive immediately (async); no partial write completes; wr_done not pulsed.
//  - Bus never passes directly LATCH->WRITE or WRITE->LATCH without GAP when GAP_CYCLES>0.
// TESTING
//  1 Defaults; req R7=0x38 -> cyc1-2 DA=0x07 bdir/bc1=11; cyc3 00; cyc4-5 DA=0x38 10; cyc6 00; cyc7 wr_done=1.
//  2 Back-to-back R0=0x55 then R0=0xAA, SKIP_RELATCH=1 -> 2nd has no latch phase, wr_done 4 cycles after accept.
//  3 As 2 with cache_flush pulse between -> 2nd sequence re-latches R0 (DA=0x00, bdir/bc1=11 for 2 cycles).
//  4 GAP_CYCLES=0, CHIP_MASK=4'hA, req R13=0x0E -> DA=0xAD 11 x2, DA=0x0E 10 x2, wr_done next cycle; no 00 cycle.
//  5 rst_n low during WRITE -> bdir=bc1=0, bus_data=0 same cycle; no wr_done; after release R1 write runs normally.
//  6 Loopback into tt_um_rejunity_ay8913: write R0..R13 values 0x01..0x0E -> PSG register file matches exactly.

Source files
------------

// File: rtl/ay8913_bus_writer.sv
// Host-side AY-3-891x register-bus writer: turns (register, value) requests into
// Latch-Address / Inactive / Write / Inactive BDIR-BC1 phases with programmable lengths.
module ay8913_bus_writer #(
  parameter logic [3:0] CHIP_MASK    = 4'b0000,
  parameter int         LATCH_CYCLES = 2,
  parameter int         WRITE_CYCLES = 2,
  parameter int         GAP_CYCLES   = 1,
  parameter bit         SKIP_RELATCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_reg,
  input  logic [7:0] in_data,
  input  logic       cache_flush,
  output logic [7:0] bus_data,
  output logic       bdir,
  output logic       bc1,
  output logic       wr_done
);

  localparam int MAX_LW  = (LATCH_CYCLES > WRITE_CYCLES) ? LATCH_CYCLES : WRITE_CYCLES;
  localparam int MAX_CYC = (MAX_LW > GAP_CYCLES) ? MAX_LW : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP_A, S_WRITE, S_GAP_B} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_load;
  logic [7:0]      r_data;
  logic [7:0]      r_bus_data;
  logic            r_bdir, r_bc1, r_wr_done;
  logic            r_cache_vld;
  logic [3:0]      r_cache_reg;
  logic            w_accept, w_skip;

  assign in_ready = (r_state == S_IDLE);
  assign bus_data = r_bus_data;
  assign bdir     = r_bdir;
  assign bc1      = r_bc1;
  assign wr_done  = r_wr_done;

  // The skip decision reads the cache as registered, so a coincident flush cannot affect it.
  assign w_skip = SKIP_RELATCH && r_cache_vld && (in_reg == r_cache_reg);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = w_skip ? S_WRITE : S_LATCH;
        end
      end
      S_LATCH: if (r_cnt == '0) w_next = (GAP_CYCLES > 0) ? S_GAP_A : S_WRITE;
      S_GAP_A: if (r_cnt == '0) w_next = S_WRITE;
      S_WRITE: if (r_cnt == '0) w_next = (GAP_CYCLES > 0) ? S_GAP_B : S_IDLE;
      S_GAP_B: if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_load = '0;
    unique case (w_next)
      S_LATCH:          w_cnt_load = CW'(LATCH_CYCLES - 1);
      S_WRITE:          w_cnt_load = CW'(WRITE_CYCLES - 1);
      S_GAP_A, S_GAP_B: w_cnt_load = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
      default:          w_cnt_load = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_cnt <= w_cnt_load;
      else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
    end
  end

  // Bus outputs are registered from the next state so each phase lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_data <= '0;
      r_bdir     <= 1'b0;
      r_bc1      <= 1'b0;
      r_wr_done  <= 1'b0;
      r_data     <= '0;
    end else begin
      r_bdir    <= (w_next == S_LATCH) || (w_next == S_WRITE);
      r_bc1     <= (w_next == S_LATCH);
      r_wr_done <= (r_state != S_IDLE) && (w_next == S_IDLE);
      if (w_accept) begin
        r_data     <= in_data;
        r_bus_data <= (w_next == S_LATCH) ? {CHIP_MASK, in_reg} : in_data;
      end else if ((w_next == S_WRITE) && (r_state != S_WRITE)) begin
        r_bus_data <= r_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_vld <= 1'b0;
      r_cache_reg <= '0;
    end else begin
      if (w_accept && (w_next == S_LATCH)) r_cache_reg <= in_reg;
      if (cache_flush)                                 r_cache_vld <= 1'b0;
      else if (w_accept && (w_next == S_LATCH))        r_cache_vld <= 1'b1;
    end
  end

endmodule
